// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: picks the older lane's branch/jalr redirect, holds it across
// hazard stalls, and drives PC enables, redirect PCs and decode/execute flush bubbles.
module fetch_redirect_ctrl #(
   parameter int WIDTH        = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_req,
   input  logic [1:0]       kind1,
   input  logic [WIDTH-1:0] target1,
   input  logic [1:0]       kind2,
   input  logic [WIDTH-1:0] target2,
   output logic             en1,
   output logic             en2,
   output logic             redir_valid,
   output logic [WIDTH-1:0] redir_pc1,
   output logic [WIDTH-1:0] redir_pc2,
   output logic             flush_d,
   output logic             flush_e,
   output logic [31:0]      redir_count,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      HOLD  = 2'b01,
      FLUSH = 2'b10
   } state_t;

   state_t           st_q, st_d;
   logic [3:0]       bub_q, bub_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             req1, req2, req, apply;
   logic [WIDTH-1:0] tgt1, tgt2, sel_tgt;

   assign state = st_q;

   assign req1 = (kind1 == 2'b01) || (kind1 == 2'b10);
   assign req2 = (kind2 == 2'b01) || (kind2 == 2'b10);
   assign req  = req1 || req2;

   // jalr targets come straight from the ALU, so drop the low bits to stay word aligned
   assign tgt1    = (kind1 == 2'b10) ? {target1[WIDTH-1:2], 2'b00} : target1;
   assign tgt2    = (kind2 == 2'b10) ? {target2[WIDTH-1:2], 2'b00} : target2;
   assign sel_tgt = req1 ? tgt1 : tgt2;

   assign redir_pc2 = redir_pc1 + WIDTH'(4);

   always_comb begin
      en1         = 1'b1;
      en2         = 1'b1;
      redir_valid = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
      redir_pc1   = sel_tgt;
      apply       = 1'b0;
      st_d        = st_q;
      bub_d       = bub_q;
      pend_d      = pend_q;
      case (st_q)
         RUN: begin
            if (stall_req) begin
               en1 = 1'b0;
               en2 = 1'b0;
               if (req) begin
                  pend_d = sel_tgt;
                  st_d   = HOLD;
               end
            end else if (req) begin
               apply = 1'b1;
            end
         end
         HOLD: begin
            redir_pc1 = pend_q;
            if (stall_req) begin
               en1 = 1'b0;
               en2 = 1'b0;
            end else begin
               apply = 1'b1;
            end
         end
         FLUSH: begin
            // lanes here are squashed, so their kinds and the stall request are ignored
            flush_d = 1'b1;
            if (bub_q <= 4'd1) begin
               st_d  = RUN;
               bub_d = 4'd0;
            end else begin
               bub_d = bub_q - 4'd1;
            end
         end
         default: st_d = RUN;
      endcase
      if (apply) begin
         redir_valid = 1'b1;
         flush_d     = 1'b1;
         flush_e     = 1'b1;
         if (FLUSH_CYCLES == 1) begin
            st_d  = RUN;
            bub_d = 4'd0;
         end else begin
            st_d  = FLUSH;
            bub_d = 4'(FLUSH_CYCLES - 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q        <= RUN;
         bub_q       <= 4'd0;
         pend_q      <= '0;
         redir_count <= '0;
      end else begin
         st_q   <= st_d;
         bub_q  <= bub_d;
         pend_q <= pend_d;
         if (apply && (redir_count != 32'hFFFF_FFFF))
            redir_count <= redir_count + 32'd1;
      end
   end

endmodule
